// File: rtl/occ_fetch_pkg.sv
// Occ fetch shared types and defaults.
// State enum, width defaults and half-select constants.
package occ_fetch_pkg;

  localparam int OCC_ADDR_W = 8;
  localparam int OCC_DATA_W = 32;
  localparam int OCC_HALF_W = 16;

  localparam logic OCC_LO = 1'b0;
  localparam logic OCC_HI = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAPT
  } occ_state_e;

endpackage

// File: rtl/occ_fetch.sv
// Occ memory front-end: two-beat RAM read with a one-entry tag cache.
// Ports: clk/rst, ce/addr request, flush, data/valid/busy out, RAM port.
module occ_fetch
  import occ_fetch_pkg::*;
#(
  parameter int ADDR_W = OCC_ADDR_W,
  parameter int DATA_W = OCC_DATA_W,
  parameter int HALF_W = OCC_HALF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_rom_Occ_i,
  input  logic [ADDR_W-1:0] addr_rom_Occ_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_Occ_o,
  output logic              data_valid_o,
  output logic              busy_o,
  output logic              ram_en_o,
  output logic [ADDR_W:0]   ram_addr_o,
  input  logic [HALF_W-1:0] ram_data_i
);

  occ_state_e        state;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] tag;
  logic [ADDR_W-1:0] served_addr;
  logic              tag_valid;
  logic              served;
  logic              no_fill;
  logic [HALF_W-1:0] lo_q;
  logic              pending;
  logic              hit;

  // A request already answered is not re-served while held unchanged.
  assign pending = ce_rom_Occ_i &&
                   !(served && addr_rom_Occ_i == served_addr);
  // A same-cycle flush turns a would-be hit into a miss.
  assign hit     = tag_valid && !flush_i &&
                   addr_rom_Occ_i == tag;
  assign busy_o  = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_addr     <= '0;
      tag          <= '0;
      served_addr  <= '0;
      tag_valid    <= 1'b0;
      served       <= 1'b0;
      no_fill      <= 1'b0;
      lo_q         <= '0;
      data_Occ_o   <= '0;
      data_valid_o <= 1'b0;
      ram_en_o     <= 1'b0;
      ram_addr_o   <= '0;
    end else begin
      data_valid_o <= 1'b0;
      if (!ce_rom_Occ_i || addr_rom_Occ_i != served_addr)
        served <= 1'b0;
      if (flush_i)
        tag_valid <= 1'b0;
      // Flush while fetching: the returning word must not refill the tag.
      if (flush_i && state != IDLE)
        no_fill <= 1'b1;
      unique case (state)
        IDLE: begin
          if (pending) begin
            if (hit) begin
              data_valid_o <= 1'b1;
              served       <= 1'b1;
              served_addr  <= addr_rom_Occ_i;
            end else begin
              req_addr   <= addr_rom_Occ_i;
              no_fill    <= 1'b0;
              ram_en_o   <= 1'b1;
              ram_addr_o <= {addr_rom_Occ_i, OCC_LO};
              state      <= RD_LO;
            end
          end
        end
        RD_LO: begin
          ram_addr_o <= {req_addr, OCC_HI};
          state      <= RD_HI;
        end
        RD_HI: begin
          lo_q     <= ram_data_i;
          ram_en_o <= 1'b0;
          state    <= CAPT;
        end
        CAPT: begin
          data_Occ_o <= {ram_data_i, lo_q};
          if (!flush_i && !no_fill) begin
            tag       <= req_addr;
            tag_valid <= 1'b1;
          end
          if (ce_rom_Occ_i && addr_rom_Occ_i == req_addr) begin
            data_valid_o <= 1'b1;
            served       <= 1'b1;
            served_addr  <= req_addr;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occ_fetch.sv
// Scoreboard bench for occ_fetch with a 1-cycle-latency RAM model.
// Directed requests push expected words; a monitor checks each pulse.
module tb_occ_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [7:0]  addr;
  logic        flush;
  logic [31:0] data;
  logic        valid;
  logic        busy;
  logic        ram_en;
  logic [8:0]  ram_addr;
  logic [15:0] ram_data;

  logic [15:0] mem [512];
  logic [31:0] exp_q [$];
  int          applied = 0;
  int          errors  = 0;

  occ_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .ce_rom_Occ_i   (ce),
    .addr_rom_Occ_i (addr),
    .flush_i        (flush),
    .data_Occ_o     (data),
    .data_valid_o   (valid),
    .busy_o         (busy),
    .ram_en_o       (ram_en),
    .ram_addr_o     (ram_addr),
    .ram_data_i     (ram_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ram_en) ram_data <= mem[ram_addr];

  always @(negedge clk) begin
    if (!rst && valid) begin
      applied++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse: unexpected data_valid, data=%h", data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          errors++;
          $display("FAIL pulse_data: got %h want %h", data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 3 + 1);
    mem[9'h00A] = 16'h1234;
    mem[9'h00B] = 16'hABCD;
    mem[9'h00C] = 16'h9ABC;
    mem[9'h00D] = 16'h5678;
    mem[9'h00E] = 16'h1111;
    mem[9'h00F] = 16'h2222;
    ram_data = '0;
    rst = 1'b1; ce = 1'b0; addr = '0; flush = 1'b0;
    step(); step(); step();
    chk("rst_data", data, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(ram_en), 0);
    chk("rst_raddr", 32'(ram_addr), 0);
    rst = 1'b0;
    step();

    // miss at 0x05
    ce = 1'b1; addr = 8'h05; exp_q.push_back(32'hABCD1234);
    step();
    chk("m1_c1_en", 32'(ram_en), 1);
    chk("m1_c1_ra", 32'(ram_addr), 32'h00A);
    chk("m1_c1_busy", 32'(busy), 1);
    step();
    chk("m1_c2_en", 32'(ram_en), 1);
    chk("m1_c2_ra", 32'(ram_addr), 32'h00B);
    step();
    chk("m1_c3_en", 32'(ram_en), 0);
    chk("m1_c3_busy", 32'(busy), 1);
    chk("m1_c3_valid", 32'(valid), 0);
    step();
    chk("m1_c4_valid", 32'(valid), 1);
    chk("m1_c4_busy", 32'(busy), 0);
    chk("m1_c4_data", data, 32'hABCD1234);
    step();
    chk("m1_c5_valid", 32'(valid), 0);

    // ce low one cycle, then hit at 0x05
    ce = 1'b0;
    step();
    ce = 1'b1; exp_q.push_back(32'hABCD1234);
    step();
    chk("h1_c1_valid", 32'(valid), 1);
    chk("h1_c1_en", 32'(ram_en), 0);
    chk("h1_c1_data", data, 32'hABCD1234);
    step();
    chk("h1_c2_valid", 32'(valid), 0);
    chk("h1_c2_en", 32'(ram_en), 0);

    // ce held, address moves to 0x06
    addr = 8'h06; exp_q.push_back(32'h56789ABC);
    step();
    chk("m2_c1_ra", 32'(ram_addr), 32'h00C);
    step();
    chk("m2_c2_ra", 32'(ram_addr), 32'h00D);
    step();
    step();
    chk("m2_c4_valid", 32'(valid), 1);
    step();
    step();
    chk("m2_hold_valid", 32'(valid), 0);
    chk("m2_hold_busy", 32'(busy), 0);

    // ce drops in C2 of a miss at 0x07: no pulse
    addr = 8'h07;
    step();
    step();
    ce = 1'b0;
    step();
    step();
    chk("m3_c4_valid", 32'(valid), 0);
    chk("m3_c4_busy", 32'(busy), 0);
    step();
    ce = 1'b1; exp_q.push_back(32'h22221111);
    step();
    chk("h2_c1_valid", 32'(valid), 1);
    chk("h2_c1_en", 32'(ram_en), 0);
    step();

    // flush, then 0x05 must miss again
    ce = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    ce = 1'b1; addr = 8'h05; exp_q.push_back(32'hABCD1234);
    step();
    chk("f_c1_en", 32'(ram_en), 1);
    chk("f_c1_ra", 32'(ram_addr), 32'h00A);
    step();
    step();
    step();
    chk("f_c4_valid", 32'(valid), 1);
    step();

    // reset in RD_HI
    ce = 1'b0;
    step();
    ce = 1'b1; addr = 8'h06;
    step();
    step();
    chk("r_rdhi_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    chk("r_valid", 32'(valid), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_en", 32'(ram_en), 0);
    chk("r_raddr", 32'(ram_addr), 0);
    chk("r_data", data, 0);
    rst = 1'b0; ce = 1'b0;
    step();
    ce = 1'b1; addr = 8'h05; exp_q.push_back(32'hABCD1234);
    step();
    chk("r2_c1_en", 32'(ram_en), 1);
    chk("r2_c1_ra", 32'(ram_addr), 32'h00A);
    step();
    step();
    step();
    chk("r2_c4_valid", 32'(valid), 1);
    step();
    ce = 1'b0;
    step();
    step();
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             applied, errors);
    $finish;
  end

endmodule
